// File: rtl/pool_flatten_writer.sv
// 2x2 max-pool write side: folds each 4-beat window into a signed maximum
// and writes the pooled values sequentially into the flatten BRAM.
module pool_flatten_writer #(
    parameter int DATA_WIDTH             = 16,
    parameter int ADDRESS_LENGTH_FLATTEN = 8,
    parameter int OUT_COUNT              = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              start,
    input  logic                              clear,
    input  logic                              in_valid,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic                              ena_flatten,
    output logic                              wea_flatten,
    output logic [ADDRESS_LENGTH_FLATTEN-1:0] addra_flatten,
    output logic [DATA_WIDTH-1:0]             dina_flatten,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);
    localparam int AW = ADDRESS_LENGTH_FLATTEN;
    localparam int DW = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           phase_q, phase_d;
    logic [AW-1:0]        out_idx_q, out_idx_d;
    logic signed [DW-1:0] max_q, max_d;
    logic                 ena_q, ena_d;
    logic [AW-1:0]        addra_q, addra_d;
    logic [DW-1:0]        dina_q, dina_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic signed [DW-1:0] in_s;
    logic signed [DW-1:0] cand;
    logic                 last_wr;

    assign in_s    = in_data;
    assign cand    = (in_s > max_q) ? in_s : max_q;
    // The write cycle of the final window closes the map; out_idx still
    // points at the address being written during that cycle.
    assign last_wr = ena_q && (out_idx_q == AW'(OUT_COUNT - 1));

    // Next-state, window accumulation and registered BRAM strobes.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        out_idx_d = out_idx_q;
        max_d     = max_q;
        ena_d     = 1'b0;
        addra_d   = addra_q;
        dina_d    = dina_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        if (clear) begin
            // Abort wins over everything, including a 4th beat this cycle.
            state_d   = IDLE;
            busy_d    = 1'b0;
            phase_d   = 2'd0;
            out_idx_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = ACCUM;
                        busy_d    = 1'b1;
                        phase_d   = 2'd0;
                        out_idx_d = '0;
                        err_d     = 1'b0;
                    end
                    if (in_valid) err_d = 1'b1;
                end
                ACCUM: begin
                    if (last_wr) begin
                        state_d   = DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        phase_d   = 2'd0;
                        out_idx_d = '0;
                    end else begin
                        // Address advances once the write has been presented.
                        if (ena_q) out_idx_d = out_idx_q + AW'(1);
                        if (in_valid) begin
                            phase_d = phase_q + 2'd1;
                            case (phase_q)
                                2'd0:    max_d = in_s;
                                2'd3: begin
                                    ena_d   = 1'b1;
                                    addra_d = out_idx_q;
                                    dina_d  = cand;
                                end
                                default: max_d = cand;
                            endcase
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    if (in_valid) err_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            phase_q   <= 2'd0;
            out_idx_q <= '0;
            max_q     <= '0;
            ena_q     <= 1'b0;
            addra_q   <= '0;
            dina_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            out_idx_q <= out_idx_d;
            max_q     <= max_d;
            ena_q     <= ena_d;
            addra_q   <= addra_d;
            dina_q    <= dina_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ena_flatten   = ena_q;
    assign wea_flatten   = ena_q;
    assign addra_flatten = addra_q;
    assign dina_flatten  = dina_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule

// File: tb/tb_pool_flatten_writer.sv
// Scoreboard bench for pool_flatten_writer: stimulus pushes expected writes
// and done pulses; a negedge monitor pops and compares them.
module tb_pool_flatten_writer;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        ena_flatten, wea_flatten, busy, done, err;
    logic [7:0]  addra_flatten;
    logic [15:0] dina_flatten;

    pool_flatten_writer #(.DATA_WIDTH(16), .ADDRESS_LENGTH_FLATTEN(8), .OUT_COUNT(16)) dut (
        .clk(clk), .rstn(rstn), .start(start), .clear(clear),
        .in_valid(in_valid), .in_data(in_data),
        .ena_flatten(ena_flatten), .wea_flatten(wea_flatten),
        .addra_flatten(addra_flatten), .dina_flatten(dina_flatten),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    wr_t exp_q[$];
    int  done_q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every presented write / done pulse must match the scoreboard.
    always @(negedge clk) begin
        if (rstn && ena_flatten) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", {24'd0, addra_flatten}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", {24'd0, addra_flatten}, {24'd0, e.addr});
                chk("write_data", {16'd0, dina_flatten}, {16'd0, e.data});
                chk("write_cycle", cyc, e.cyc);
                chk("write_wea", {31'd0, wea_flatten}, 32'd1);
            end
        end
        if (rstn && done) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                chk("done_cycle", cyc, done_q.pop_front());
                chk("done_busy_low", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    // One window: beats b[0..3] with 'gap' idle cycles between beats.
    task automatic group(input logic [15:0] b0, input logic [15:0] b1,
                         input logic [15:0] b2, input logic [15:0] b3,
                         input logic [15:0] exp_d, input logic [7:0] addr,
                         input int gap, input bit last, input bit expect_wr);
        logic [15:0] b [4];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = b[i];
            if (i == 3 && expect_wr) begin
                exp_q.push_back('{addr: addr, data: exp_d, cyc: cyc + 1});
                if (last) done_q.push_back(cyc + 2);
            end
            tick(1);
            in_valid = 1'b0;
            if (i < 3) tick(gap);
        end
    endtask

    // Full map: group k = {k+base, k+base+3, k+base+1, k+base+2} -> k+base+3.
    task automatic full_map(input int base, input bit gapped);
        for (int k = 0; k < 16; k++) begin
            logic [15:0] v;
            v = 16'(k + base);
            group(v, v + 16'd3, v + 16'd1, v + 16'd2, v + 16'd3, 8'(k),
                  gapped ? (k % 4) : 0, k == 15, 1'b1);
        end
    endtask

    initial begin
        // Reset state
        tick(2);
        chk("rst_ena", {31'd0, ena_flatten}, 32'd0);
        chk("rst_wea", {31'd0, wea_flatten}, 32'd0);
        chk("rst_addr", {24'd0, addra_flatten}, 32'd0);
        chk("rst_data", {16'd0, dina_flatten}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rstn = 1'b1;
        tick(2);

        // 1: single map, back-to-back
        pulse_start();
        chk("s1_busy", {31'd0, busy}, 32'd1);
        full_map(0, 1'b0);
        tick(3);
        chk("s1_busy_after", {31'd0, busy}, 32'd0);

        // 2: signed max, then abort the map
        pulse_start();
        group(16'hFFF0, 16'h8000, 16'hFFFE, 16'hFFF5, 16'hFFFE, 8'd0, 0, 1'b0, 1'b1);
        group(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 8'd1, 0, 1'b0, 1'b1);
        group(16'h7FFF, 16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 8'd2, 1, 1'b0, 1'b1);
        pulse_clear();
        chk("s2_busy_clear", {31'd0, busy}, 32'd0);
        tick(2);

        // 3: gapped input
        pulse_start();
        full_map(0, 1'b1);
        tick(3);

        // 4: clear with 3rd beat of group 5, then clear with a 4th beat
        pulse_start();
        for (int k = 0; k < 5; k++)
            group(16'(k), 16'(k + 3), 16'(k + 1), 16'(k + 2), 16'(k + 3), 8'(k), 0, 1'b0, 1'b1);
        in_valid = 1'b1; in_data = 16'd50; tick(1);
        in_data = 16'd51; tick(1);
        in_data = 16'd52; clear = 1'b1; tick(1);
        in_valid = 1'b0; clear = 1'b0;
        chk("s4_busy_clear", {31'd0, busy}, 32'd0);
        tick(2);
        pulse_start();
        in_valid = 1'b1; in_data = 16'd1; tick(1);
        in_data = 16'd2; tick(1);
        in_data = 16'd3; tick(1);
        in_data = 16'd4; clear = 1'b1; tick(1);
        in_valid = 1'b0; clear = 1'b0;
        tick(2);
        chk("s4_err_clean", {31'd0, err}, 32'd0);
        pulse_start();
        full_map(100, 1'b0);
        tick(3);

        // 5: protocol errors
        in_valid = 1'b1; in_data = 16'h1234; tick(1);
        in_valid = 1'b0;
        chk("s5_err_idle", {31'd0, err}, 32'd1);
        tick(2);
        pulse_start();
        chk("s5_err_cleared", {31'd0, err}, 32'd0);
        for (int k = 0; k < 2; k++)
            group(16'(k), 16'(k + 3), 16'(k + 1), 16'(k + 2), 16'(k + 3), 8'(k), 0, 1'b0, 1'b1);
        pulse_start();
        chk("s5_busy_midstart", {31'd0, busy}, 32'd1);
        for (int k = 2; k < 16; k++)
            group(16'(k), 16'(k + 3), 16'(k + 1), 16'(k + 2), 16'(k + 3), 8'(k), 0, k == 15, 1'b1);
        tick(3);
        chk("s5_err_map", {31'd0, err}, 32'd0);
        in_valid = 1'b1; in_data = 16'h0BAD; tick(1);
        in_valid = 1'b0;
        chk("s5_err_again", {31'd0, err}, 32'd1);

        // 6: async reset during the write cycle of group 3
        pulse_start();
        for (int k = 0; k < 4; k++)
            group(16'(k), 16'(k + 3), 16'(k + 1), 16'(k + 2), 16'(k + 3), 8'(k), 0, 1'b0, k < 3);
        rstn = 1'b0;
        #1;
        chk("s6_ena", {31'd0, ena_flatten}, 32'd0);
        chk("s6_addr", {24'd0, addra_flatten}, 32'd0);
        chk("s6_data", {16'd0, dina_flatten}, 32'd0);
        chk("s6_busy", {31'd0, busy}, 32'd0);
        chk("s6_err", {31'd0, err}, 32'd0);
        tick(2);
        rstn = 1'b1;
        tick(2);
        chk("s6_done_idle", {31'd0, done}, 32'd0);
        pulse_start();
        full_map(7, 1'b1);
        tick(4);

        // Nothing left outstanding
        chk("pending_writes", exp_q.size(), 32'd0);
        chk("pending_done", done_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
